imm_split: RTL

IMM_SPLIT -- requirements
Module: imm_split

---
 rtl/imm_split_pkg.sv | 28 ++
 rtl/imm_classify.sv | 68 ++++++
 rtl/imm_split.sv | 125 ++++++++++++
 3 files changed

// File: rtl/imm_split_pkg.sv
// -----------------------------------------------------------------------------
// imm_split_pkg
// Shared definitions for the 32-bit constant splitter:
//   - extend-mode (EOp) encodings understood by the downstream immediate
//     extender
//   - FSM state encoding of imm_split
//   - packed op record used for the pending (second) operation
// -----------------------------------------------------------------------------
package imm_split_pkg;

  // Extend modes; the consumer feeds imm/EOp straight into its extender.
  localparam logic [1:0] EOP_SEXT = 2'b00;  // sign-extend imm to 32 bits
  localparam logic [1:0] EOP_ZEXT = 2'b01;  // zero-extend imm to 32 bits
  localparam logic [1:0] EOP_LUI  = 2'b10;  // imm placed in bits [31:16]
  localparam logic [1:0] EOP_SHL2 = 2'b11;  // sign-extend, then shift left 2

  typedef enum logic [1:0] {
    ST_EMPTY      = 2'd0,  // no op held
    ST_HOLD_LAST  = 2'd1,  // a last=1 op is presented
    ST_HOLD_FIRST = 2'd2   // first op of a pair presented, second pending
  } state_t;

  typedef struct packed {
    logic [15:0] imm;
    logic [1:0]  eop;
  } op_t;

endpackage

// File: rtl/imm_classify.sv
// -----------------------------------------------------------------------------
// imm_classify
// Purely combinational decomposition of a 32-bit constant into one or two
// extend operations. Checks run in priority order; the first match wins,
// so the cheapest single-op form is always chosen.
//
// Ports:
//   value       in   32  constant to decompose
//   first_imm   out  16  immediate of the first (or only) op
//   first_eop   out   2  extend mode of the first op
//   second_imm  out  16  immediate of the second op (0 when single-op)
//   second_eop  out   2  extend mode of the second op (0 when single-op)
//   two_op      out   1  1 when the constant needs a LUI + ZEXT pair
// -----------------------------------------------------------------------------
module imm_classify
  import imm_split_pkg::*;
(
  input  logic [31:0] value,
  output logic [15:0] first_imm,
  output logic [1:0]  first_eop,
  output logic [15:0] second_imm,
  output logic [1:0]  second_eop,
  output logic        two_op
);

  logic w_sext_ok;  // bits [31:15] all copies of one bit
  logic w_zext_ok;
  logic w_lui_ok;
  logic w_shl2_ok;  // word-aligned and bits [31:17] all copies of one bit

  assign w_sext_ok = (&value[31:15]) | ~(|value[31:15]);
  assign w_zext_ok = (value[31:16] == 16'h0000);
  assign w_lui_ok  = (value[15:0]  == 16'h0000);
  assign w_shl2_ok = (value[1:0] == 2'b00) &&
                     ((&value[31:17]) | ~(|value[31:17]));

  // NOTE: every output gets a default first, so no path through the
  // if/else chain can leave one unassigned and infer a latch.
  always_comb begin
    first_imm  = value[15:0];
    first_eop  = EOP_SEXT;
    second_imm = 16'h0000;
    second_eop = EOP_SEXT;
    two_op     = 1'b0;

    if (w_sext_ok) begin
      first_imm = value[15:0];
      first_eop = EOP_SEXT;
    end else if (w_zext_ok) begin
      first_imm = value[15:0];
      first_eop = EOP_ZEXT;
    end else if (w_lui_ok) begin
      first_imm = value[31:16];
      first_eop = EOP_LUI;
    end else if (w_shl2_ok) begin
      first_imm = value[17:2];
      first_eop = EOP_SHL2;
    end else begin
      // High half replaces the accumulator, low half is ORed in.
      first_imm  = value[31:16];
      first_eop  = EOP_LUI;
      second_imm = value[15:0];
      second_eop = EOP_ZEXT;
      two_op     = 1'b1;
    end
  end

endmodule

// File: rtl/imm_split.sv
// -----------------------------------------------------------------------------
// imm_split
// Accepts 32-bit constants over a valid/ready handshake and emits the
// sequence of extend operations (one or two) that rebuilds each constant.
// All outputs are registered; an accepted constant's first op appears one
// cycle after the accepting edge. For a pair, the second op waits in a
// pending register until the first op is taken.
//
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   in_valid   in   1   value carries a constant
//   in_ready   out  1   constant accepted this cycle when in_valid=1
//   value      in   32  constant to decompose
//   out_valid  out  1   an op is presented
//   out_ready  in   1   consumer takes the presented op
//   imm        out  16  immediate of the presented op
//   EOp        out  2   extend mode of the presented op
//   combine    out  1   0: replace accumulator, 1: OR into previous result
//   last       out  1   final op for the current constant
// -----------------------------------------------------------------------------
module imm_split
  import imm_split_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] imm,
  output logic [1:0]  EOp,
  output logic        combine,
  output logic        last
);

  state_t      r_state;
  logic        r_out_valid;
  logic [15:0] r_imm;
  logic [1:0]  r_eop;
  logic        r_combine;
  logic        r_last;
  op_t         r_pend;

  logic [15:0] w_first_imm;
  logic [1:0]  w_first_eop;
  logic [15:0] w_second_imm;
  logic [1:0]  w_second_eop;
  logic        w_two_op;
  logic        w_accept;
  logic        w_out_hs;

  imm_classify u_classify (
    .value      (value),
    .first_imm  (w_first_imm),
    .first_eop  (w_first_eop),
    .second_imm (w_second_imm),
    .second_eop (w_second_eop),
    .two_op     (w_two_op)
  );

  // A new constant may enter only when the output slot is free or is being
  // vacated by a last op this cycle; a pending second op always blocks.
  assign in_ready = !reset &&
                    ((r_state == ST_EMPTY) ||
                     ((r_state == ST_HOLD_LAST) && out_ready));

  assign w_accept = in_valid && in_ready;
  assign w_out_hs = r_out_valid && out_ready;

  // NOTE: reset is sampled on the clock edge like any other input; the
  // pending register is cleared too, so a pair interrupted by reset can
  // never leak its second op afterwards.
  // NOTE: state is updated with non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_imm       <= 16'h0000;
      r_eop       <= EOP_SEXT;
      r_combine   <= 1'b0;
      r_last      <= 1'b0;
      r_pend      <= '0;
    end else begin
      case (r_state)
        ST_HOLD_FIRST: begin
          if (w_out_hs) begin
            r_state   <= ST_HOLD_LAST;
            r_imm     <= r_pend.imm;
            r_eop     <= r_pend.eop;
            r_combine <= 1'b1;
            r_last    <= 1'b1;
          end
        end
        ST_HOLD_LAST, ST_EMPTY: begin
          if (w_accept) begin
            r_state     <= w_two_op ? ST_HOLD_FIRST : ST_HOLD_LAST;
            r_out_valid <= 1'b1;
            r_imm       <= w_first_imm;
            r_eop       <= w_first_eop;
            r_combine   <= 1'b0;
            r_last      <= !w_two_op;
            r_pend      <= '{imm: w_second_imm, eop: w_second_eop};
          end else if (w_out_hs) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign imm       = r_imm;
  assign EOp       = r_eop;
  assign combine   = r_combine;
  assign last      = r_last;

endmodule
